alu_iterative: RTL and testbench
================================

Name: alu_iterative

Overview:
Parametrised successor to the combinational integer ALU. Executes RV32I/RV64I OP-IMM and OP integer operations, plus the M extension (MUL/MULH*/DIV*/REM*).
- Inputs arrive on a valid/ready handshake; results leave on a valid/ready handshake.
- Single-cycle ops have 1-cycle registered latency; divide/remainder runs on an iterative radix-2 engine.
- Sits in the execute stage; the pipeline stalls on in_ready/out_valid.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
M_EXT, 1, 1 = M-extension ops decoded; 0 = M encodings are illegal.
SHW, $clog2(XLEN), shift-amount width (derived; never overridden).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of in-flight/pending op
in_valid  in  1  request valid
in_ready  out  1  block can accept this cycle
op1  in  XLEN  rs1 value
op2  in  XLEN  rs2 value or sign-extended immediate
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7 (imm[11:5] for OP-IMM)
insn_type  in  3  3'b000 = OP-IMM, 3'b001 = OP; others illegal
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  registered result
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert): state=IDLE, out_valid=0, result=0, busy=0, divider registers cleared. in_ready=1 from the first clock after deassert.
- FSM states:
  - IDLE -> accept: if DIV/DIVU/REM/REMU with a non-special case, go to DIV; otherwise go to HOLD.
  - DIV -> HOLD after exactly XLEN iteration cycles.
  - HOLD -> out_ready=1: go to IDLE, or straight back to a new accept if in_valid.
- in_ready = (state==IDLE) || (state==HOLD && out_ready), gated low when flush=1. This gives 1 op/cycle throughput for single-cycle ops.
- Operands, funct and type are captured at accept; inputs need not stay stable afterwards.
- Latency (accept edge to out_valid rising):
  - 1 cycle for all non-divide ops and illegal encodings.
  - XLEN+1 cycles for normal divide/remainder.
- In HOLD, out_valid=1 and result is held stable until out_ready.
- Shifts: shamt = op2[SHW-1:0]. The legality check compares funct7[6:SHW-5] only, so XLEN=64 frees funct7[0] for shamt.
- OP-IMM decode:
  - ADDI, SLTI (signed), SLTIU (unsigned), XORI, ORI, ANDI.
  - SLLI needs funct7==0.
  - SRLI needs funct7==0000000; SRAI needs funct7==0100000.
- OP decode:
  - funct7 0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7 0100000: SUB (f3=000), SRA (f3=101).
  - funct7 0000001 (M_EXT=1): f3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Multiply: full 2*XLEN product computed combinationally and registered. MUL returns the low half; MULH/MULHSU/MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Divide special cases resolve in 1 cycle, no DIV state:
  - divisor 0: DIV/DIVU -> all ones; REM/REMU -> op1.
  - signed overflow (op1 = most-negative, op2 = -1): DIV -> op1; REM -> 0.
- Divide normal path:
  - Signed ops divide magnitudes, then apply signs: quotient negated if the operand signs differ; remainder takes op1's sign.
  - Iteration counter runs 0..XLEN-1 and wraps only via the FSM exit.
- Illegal encoding or insn_type: result=0, latency 1, no exception signalled.
- flush=1 (takes effect on the same clock edge):
  - state -> IDLE, out_valid=0 next cycle, divider aborted.
  - Any in_valid in the same cycle is not accepted.
  - flush and out_ready in the same cycle: flush wins; the result is dropped.
- Reset asserted mid-divide: immediate abort, same values as power-on reset.

Decomposition:
- Shared package alu_pkg:
  - insn_type constants (INSN_OPIMM, INSN_OP);
  - funct3 encodings for base and M ops;
  - funct7 constants F7_BASE, F7_ALT, F7_MEXT;
  - state enum alu_state_t {IDLE, DIV, HOLD}.
- Sub-module alu_divider (XLEN-parametrised restoring divider):
  - inputs start, dividend, divisor, is_signed, abort;
  - outputs done, quotient, remainder.
- The top level keeps the decode, the single-cycle datapath, the multiplier, special-case detection and the handshake FSM.

Test Plan:
1. XLEN=32, OP ADD op1=5 op2=7, out_ready=1 -> out_valid 1 cycle after accept, result=12; back-to-back SUB 5-7 accepted next cycle -> 0xFFFFFFFE.
2. OP-IMM SRAI op1=0x80000000 shamt=4 funct7=0100000 -> 0xF8000000; SRLI same operands with funct7=0 -> 0x08000000; funct7=0000001 -> 0.
3. OP MULHSU op1=0xFFFFFFFF op2=0xFFFFFFFF -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE; MUL -> 0x00000001.
4. DIV op1=-7 op2=2 -> out_valid at cycle 33, result=0xFFFFFFFD; REM same -> 0xFFFFFFFF; in_ready=0 throughout cycles 1-32.
5. DIV op1=0x80000000 op2=0xFFFFFFFF -> 0x80000000 at latency 1; DIVU op2=0 -> 0xFFFFFFFF; REMU op1=9 op2=0 -> 9.
6. Start DIVU, assert flush at iteration 10 -> state IDLE, no out_valid; hold out_ready=0 on a result for 5 cycles -> result stable; async rst mid-divide -> all outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings and FSM state type for the iterative ALU
package alu_pkg;

  localparam logic [2:0] INSN_OPIMM = 3'b000;
  localparam logic [2:0] INSN_OP    = 3'b001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {IDLE, DIV, HOLD} alu_state_t;

endpackage

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - radix-2 restoring divider, one quotient bit per cycle
module alu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            abort,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int SHW = $clog2(XLEN);

  logic            active;
  logic [SHW-1:0]  count;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic            neg_q;
  logic            neg_r;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] rem_nxt;
  logic            sign_a;
  logic            sign_b;

  // One restoring step; outputs expose the step's result so the last bit is
  // available in the same cycle that done is raised.
  always_comb begin
    shifted   = {rem, quo[XLEN-1]};
    diff      = shifted - {1'b0, dvs};
    ge        = (shifted >= {1'b0, dvs});
    rem_nxt   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nxt   = {quo[XLEN-2:0], ge};
    done      = active && (count == SHW'(XLEN - 1));
    quotient  = neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
    remainder = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;
  end

  assign sign_a = is_signed && dividend[XLEN-1];
  assign sign_b = is_signed && divisor[XLEN-1];

  // Load magnitudes on start, iterate while active, stop on done or abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      count  <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (abort) begin
      active <= 1'b0;
      count  <= '0;
    end else if (start) begin
      active <= 1'b1;
      count  <= '0;
      quo    <= sign_a ? (~dividend + 1'b1) : dividend;
      rem    <= '0;
      dvs    <= sign_b ? (~divisor + 1'b1) : divisor;
      neg_q  <= sign_a ^ sign_b;
      neg_r  <= sign_a;
    end else if (active) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
      if (done) begin
        active <= 1'b0;
        count  <= '0;
      end else begin
        count <= count + SHW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// rtl/alu_iterative.sv - RV32/64 I+M execute ALU with handshakes and iterative divide
module alu_iterative
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int M_EXT = 1,
  parameter int SHW   = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [2:0]      insn_type,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  alu_state_t        state;
  logic              div_rem_q;
  logic              accept;

  logic [SHW-1:0]    shamt;
  logic              shf_base;
  logic              shf_alt;
  logic              is_divop;
  logic              div_by_zero;
  logic              div_ovf;
  logic              needs_div;
  logic              a_sgn;
  logic              b_sgn;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   sum;
  logic [XLEN-1:0]   sra_val;
  logic              slt;
  logic              sltu;
  logic [XLEN-1:0]   result_nxt;

  logic              div_done;
  logic [XLEN-1:0]   div_quotient;
  logic [XLEN-1:0]   div_remainder;

  assign in_ready = !flush && ((state == IDLE) || (state == HOLD && out_ready));
  assign accept   = in_valid && in_ready;

  // For XLEN=64 the low funct7 bit belongs to shamt, so only the upper bits gate legality.
  assign shamt    = op2[SHW-1:0];
  assign shf_base = (funct7[6:SHW-5] == F7_BASE[6:SHW-5]);
  assign shf_alt  = (funct7[6:SHW-5] == F7_ALT[6:SHW-5]);

  assign is_divop    = (M_EXT != 0) && (insn_type == INSN_OP) && (funct7 == F7_MEXT) && funct3[2];
  assign div_by_zero = (op2 == '0);
  assign div_ovf     = !funct3[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
  assign needs_div   = is_divop && !div_by_zero && !div_ovf;

  // Single full-width multiplier; operand extension selects signedness per op.
  assign a_sgn = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
  assign b_sgn = (funct3 == F3_MULH);
  assign a_ext = {{XLEN{a_sgn & op1[XLEN-1]}}, op1};
  assign b_ext = {{XLEN{b_sgn & op2[XLEN-1]}}, op2};
  assign prod  = a_ext * b_ext;

  assign sum     = op1 + op2;
  assign sra_val = $unsigned($signed(op1) >>> shamt);
  assign slt     = ($signed(op1) < $signed(op2));
  assign sltu    = (op1 < op2);

  // Result for everything that completes in one cycle, including divide special cases.
  always_comb begin
    result_nxt = '0;
    if (insn_type == INSN_OPIMM) begin
      case (funct3)
        F3_ADD:  result_nxt = sum;
        F3_SLT:  result_nxt = {{(XLEN-1){1'b0}}, slt};
        F3_SLTU: result_nxt = {{(XLEN-1){1'b0}}, sltu};
        F3_XOR:  result_nxt = op1 ^ op2;
        F3_OR:   result_nxt = op1 | op2;
        F3_AND:  result_nxt = op1 & op2;
        F3_SLL:  result_nxt = shf_base ? (op1 << shamt) : '0;
        F3_SRL:  result_nxt = shf_base ? (op1 >> shamt) : (shf_alt ? sra_val : '0);
        default: result_nxt = '0;
      endcase
    end else if (insn_type == INSN_OP) begin
      if (funct7 == F7_BASE) begin
        case (funct3)
          F3_ADD:  result_nxt = sum;
          F3_SLL:  result_nxt = op1 << shamt;
          F3_SLT:  result_nxt = {{(XLEN-1){1'b0}}, slt};
          F3_SLTU: result_nxt = {{(XLEN-1){1'b0}}, sltu};
          F3_XOR:  result_nxt = op1 ^ op2;
          F3_SRL:  result_nxt = op1 >> shamt;
          F3_OR:   result_nxt = op1 | op2;
          F3_AND:  result_nxt = op1 & op2;
          default: result_nxt = '0;
        endcase
      end else if (funct7 == F7_ALT) begin
        if (funct3 == F3_ADD)      result_nxt = op1 - op2;
        else if (funct3 == F3_SRL) result_nxt = sra_val;
      end else if ((M_EXT != 0) && (funct7 == F7_MEXT)) begin
        if (!funct3[2])       result_nxt = (funct3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (div_by_zero) result_nxt = funct3[1] ? op1 : '1;
        else if (div_ovf)     result_nxt = funct3[1] ? '0 : op1;
      end
    end
  end

  alu_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && needs_div),
    .dividend  (op1),
    .divisor   (op2),
    .is_signed (!funct3[0]),
    .abort     (flush),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  // Handshake FSM with registered result, out_valid and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      div_rem_q <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            busy <= 1'b1;
            if (needs_div) begin
              state     <= DIV;
              out_valid <= 1'b0;
              div_rem_q <= funct3[1];
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
              result    <= result_nxt;
            end
          end else if (state == HOLD && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        DIV: begin
          if (div_done) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            result    <= div_rem_q ? div_remainder : div_quotient;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// tb/tb_alu_iterative.sv - directed self-checking bench for alu_iterative
module tb_alu_iterative;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [2:0]  insn_type;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_cmp;
  int n_bad;

  alu_iterative #(.XLEN(32), .M_EXT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .funct3    (funct3),
    .funct7    (funct7),
    .insn_type (insn_type),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op expected to complete in one cycle; called at posedge+1.
  task automatic op_single(input string tag, input logic [2:0] typ, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
    insn_type = typ; funct3 = f3; funct7 = f7; op1 = a; op2 = b; in_valid = 1'b1;
    expect_eq({tag, ".rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_eq({tag, ".vld"}, 32'(out_valid), 32'd1);
    expect_eq(tag, result, exp);
  endtask

  // Issue a normal divide and measure accept-to-out_valid latency.
  task automatic op_div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int cycles;
    int rdy_hi;
    insn_type = 3'b001; funct3 = f3; funct7 = 7'b0000001; op1 = a; op2 = b; in_valid = 1'b1;
    expect_eq({tag, ".rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; op1 = '0; op2 = '0;
    cycles = 1;
    rdy_hi = 0;
    while (!out_valid && cycles < 100) begin
      if (in_ready) rdy_hi++;
      @(posedge clk); #1;
      cycles++;
    end
    expect_eq({tag, ".vld"}, 32'(out_valid), 32'd1);
    expect_eq({tag, ".lat"}, 32'(cycles), 32'd33);
    expect_eq({tag, ".busyrdy"}, 32'(rdy_hi), 32'd0);
    expect_eq(tag, result, exp);
  endtask

  initial begin
    int seen;
    int unstable;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op1 = '0; op2 = '0; funct3 = '0; funct7 = '0; insn_type = '0;
    #1;
    expect_eq("rst.out_valid", 32'(out_valid), 32'd0);
    expect_eq("rst.result", result, 32'd0);
    expect_eq("rst.busy", 32'(busy), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    expect_eq("post_rst.in_ready", 32'(in_ready), 32'd1);

    // Back-to-back single-cycle ops
    out_ready = 1'b1;
    op_single("add", 3'b001, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd12);
    op_single("sub", 3'b001, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'hFFFF_FFFE);
    op_single("srai", 3'b000, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 32'hF800_0000);
    op_single("srli", 3'b000, 3'b101, 7'b0000000, 32'h8000_0000, 32'd4, 32'h0800_0000);
    op_single("srli_bad", 3'b000, 3'b101, 7'b0000001, 32'h8000_0000, 32'd4, 32'd0);
    op_single("slti", 3'b000, 3'b010, 7'b1111111, 32'hFFFF_FFFF, 32'd1, 32'd1);
    op_single("sltiu", 3'b000, 3'b011, 7'b1111111, 32'hFFFF_FFFF, 32'd1, 32'd0);
    op_single("xor", 3'b001, 3'b100, 7'b0000000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);
    op_single("sll", 3'b001, 3'b001, 7'b0000000, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030);
    op_single("illegal_type", 3'b010, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd0);
    op_single("mulhsu", 3'b001, 3'b010, 7'b0000001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op_single("mulhu", 3'b001, 3'b011, 7'b0000001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    op_single("mul", 3'b001, 3'b000, 7'b0000001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    op_single("mulh", 3'b001, 3'b001, 7'b0000001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    op_single("div_ovf", 3'b001, 3'b100, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    op_single("rem_ovf", 3'b001, 3'b110, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    op_single("divu_zero", 3'b001, 3'b101, 7'b0000001, 32'd5, 32'd0, 32'hFFFF_FFFF);
    op_single("remu_zero", 3'b001, 3'b111, 7'b0000001, 32'd9, 32'd0, 32'd9);

    // Iterative divides
    op_div("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    op_div("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    op_div("div_negb", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    op_div("rem_negb", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1);
    op_div("divu", 3'b101, 32'd100, 32'd7, 32'd14);
    op_div("remu", 3'b111, 32'd100, 32'd7, 32'd2);
    @(posedge clk); #1;
    expect_eq("drain.busy", 32'(busy), 32'd0);

    // Flush at iteration 10 together with a competing request
    insn_type = 3'b001; funct3 = 3'b101; funct7 = 7'b0000001;
    op1 = 32'd1000; op2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    expect_eq("flush.pre_busy", 32'(busy), 32'd1);
    flush = 1'b1; funct3 = 3'b000; funct7 = 7'b0000000; in_valid = 1'b1;
    #1;
    expect_eq("flush.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    expect_eq("flush.busy", 32'(busy), 32'd0);
    expect_eq("flush.out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    expect_eq("flush.no_result", 32'(seen), 32'd0);

    // Result held under backpressure, then dropped by flush with out_ready
    out_ready = 1'b0;
    op_single("hold", 3'b001, 3'b000, 7'b0000000, 32'd20, 32'd22, 32'd42);
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!out_valid || result !== 32'd42 || in_ready) unstable++;
    end
    expect_eq("hold.stable", 32'(unstable), 32'd0);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    expect_eq("hold.flush_drop", 32'(out_valid), 32'd0);

    // Async reset mid-divide
    insn_type = 3'b001; funct3 = 3'b100; funct7 = 7'b0000001;
    op1 = 32'd1000; op2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    expect_eq("arst.out_valid", 32'(out_valid), 32'd0);
    expect_eq("arst.busy", 32'(busy), 32'd0);
    expect_eq("arst.result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    expect_eq("arst.in_ready", 32'(in_ready), 32'd1);
    op_div("div_after_rst", 3'b100, 32'd1000, 32'd3, 32'd333);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
